rom_boot_loader: RTL



---
 rtl/rom_boot_pkg.sv | 35 +++
 rtl/rom_boot_loader_if.sv | 27 ++
 rtl/boot_byte_fifo.sv | 58 +++++
 rtl/rom_boot_loader.sv | 139 +++++++++++++
 4 files changed

// File: rtl/rom_boot_pkg.sv
// Shared types and constants for the ROM boot loader.
// Latency: n/a (types, constants and a pure page-mapping function only).
// Backpressure: n/a.
package rom_boot_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // SDRAM page (boot_a[22:14]) for each 16 KiB window of a ROM file
   localparam logic [8:0] PAGE_0 = 9'h000;
   localparam logic [8:0] PAGE_1 = 9'h100;
   localparam logic [8:0] PAGE_2 = 9'h107;
   localparam logic [8:0] PAGE_3 = 9'h0ff;

   typedef struct packed {
      logic [22:0] addr;
      logic [7:0]  data;
   } fifo_entry_t;

   function automatic logic [8:0] page_of(input logic [1:0] sel);
      logic [8:0] page;
      case (sel)
         2'd0:    page = PAGE_0;
         2'd1:    page = PAGE_1;
         2'd2:    page = PAGE_2;
         default: page = PAGE_3;
      endcase
      return page;
   endfunction

endpackage

// File: rtl/rom_boot_loader_if.sv
// Bundles the HPS ioctl download port and the SDRAM boot write port.
// Latency: n/a (wires only).
// Backpressure: ioctl_wait throttles the loader; boot_req is held until boot_ack.
// Ports: master = loader/SDRAM side (drives ioctl_*, boot_ack),
//        slave  = rom_boot_loader (drives ioctl_wait, boot_req, boot_a, boot_dout).
interface rom_boot_loader_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        ioctl_wait;
   logic        boot_req;
   logic        boot_ack;
   logic [22:0] boot_a;
   logic [7:0]  boot_dout;

   modport master (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, boot_ack,
      input  ioctl_wait, boot_req, boot_a, boot_dout
   );

   modport slave (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, boot_ack,
      output ioctl_wait, boot_req, boot_a, boot_dout
   );
endinterface

// File: rtl/boot_byte_fifo.sv
// Synchronous FIFO of {addr, data} entries between ioctl capture and SDRAM writes.
// Latency: an entry pushed on an edge is at the head after that edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
// Ports: clk_48/reset_n, push/push_dat, pop, head_dat, full, empty, fill.
module boot_byte_fifo
   import rom_boot_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_48,
   input  logic                     reset_n,
   input  logic                     push,
   input  fifo_entry_t              push_dat,
   input  logic                     pop,
   output fifo_entry_t              head_dat,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   fill
);

   localparam int AW = $clog2(DEPTH);

   fifo_entry_t   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          do_push;
   logic          do_pop;

   assign full     = (count == (AW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign fill     = count;
   assign head_dat = mem[rd_ptr];
   assign do_pop   = pop & ~empty;
   assign do_push  = push & (~full | do_pop);

   // Storage needs no reset: the head is only observed while non-empty
   always_ff @(posedge clk_48) begin
      if (do_push) mem[wr_ptr] <= push_dat;
   end

   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rom_boot_loader.sv
// Copies system-ROM download bytes from the HPS ioctl port into SDRAM pages.
// Latency: a byte strobed on an edge is presented as boot_req right after that edge.
// Backpressure: ioctl_wait is registered from the next fill level; boot_req holds until boot_ack.
// Ports: clk_48, reset_n, bus (slave modport), rom_map, rom_loaded, load_done, drop_count.
module rom_boot_loader
   import rom_boot_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int WAIT_LEVEL = FIFO_DEPTH - 1
) (
   input  logic              clk_48,
   input  logic              reset_n,
   rom_boot_loader_if.slave  bus,
   output logic [255:0]      rom_map,
   output logic              rom_loaded,
   output logic              load_done,
   output logic [15:0]       drop_count
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] WAIT_LVL = (AW+1)'(WAIT_LEVEL);

   state_t      state;
   state_t      state_nxt;
   logic        dl_q;
   logic        session_q;
   logic        rom_idx;
   logic        dl_rise;
   logic        dl_fall;
   logic        rom_rise;
   logic        strobe;
   logic        bad_page;
   logic        push;
   logic        pop;
   logic        drop;
   logic        fifo_full;
   logic        fifo_empty;
   logic        wait_q;
   logic        clear_session;
   logic        set_loaded;
   logic [AW:0] fill;
   logic [AW:0] fill_nxt;
   fifo_entry_t push_dat;
   fifo_entry_t head_dat;
   logic        unused_idx;

   assign unused_idx = &{1'b0, bus.ioctl_index[7:5]};

   assign rom_idx  = (bus.ioctl_index[4:0] < 5'd4);
   assign dl_rise  = bus.ioctl_download & ~dl_q;
   assign dl_fall  = ~bus.ioctl_download & dl_q;
   assign rom_rise = dl_rise & rom_idx;
   // Bytes belong to a session only after a ROM-index rising edge has been seen
   assign strobe   = bus.ioctl_download & bus.ioctl_wr & rom_idx & (session_q | rom_rise);
   assign bad_page = |bus.ioctl_addr[24:16];
   assign pop      = ~fifo_empty & bus.boot_ack;
   assign push     = strobe & ~bad_page & (~fifo_full | pop);
   assign drop     = strobe & ~push;
   assign push_dat = '{addr: {page_of(bus.ioctl_addr[15:14]), bus.ioctl_addr[13:0]},
                       data: bus.ioctl_dout};

   boot_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_48   (clk_48),
      .reset_n  (reset_n),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .head_dat (head_dat),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .fill     (fill)
   );

   assign bus.boot_req   = ~fifo_empty;
   assign bus.boot_a     = fifo_empty ? '0 : head_dat.addr;
   assign bus.boot_dout  = fifo_empty ? '0 : head_dat.data;
   assign bus.ioctl_wait = wait_q;

   always_comb begin
      fill_nxt = fill;
      if (push & ~pop)      fill_nxt = fill + (AW+1)'(1);
      else if (pop & ~push) fill_nxt = fill - (AW+1)'(1);
   end

   // FSM: state register
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // FSM: next state
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (rom_rise && fifo_empty) state_nxt = ST_LOAD;
         ST_LOAD:  if (dl_fall)                state_nxt = ST_DRAIN;
         ST_DRAIN: if (fifo_empty)             state_nxt = ST_DONE;
         ST_DONE:                              state_nxt = ST_IDLE;
         default:                              state_nxt = ST_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      load_done     = (state == ST_DONE);
      clear_session = (state == ST_IDLE) && (state_nxt == ST_LOAD);
      set_loaded    = (state == ST_DRAIN) && (state_nxt == ST_DONE);
   end

   // dl_q resets high so a download already active across reset is not
   // mistaken for a new session; only a fresh rising edge restarts loading.
   always_ff @(posedge clk_48 or negedge reset_n) begin
      if (!reset_n) begin
         dl_q       <= 1'b1;
         session_q  <= 1'b0;
         wait_q     <= 1'b0;
         rom_map    <= '0;
         rom_loaded <= 1'b0;
         drop_count <= '0;
      end else begin
         dl_q   <= bus.ioctl_download;
         wait_q <= (fill_nxt >= WAIT_LVL);

         if (rom_rise)     session_q <= 1'b1;
         else if (dl_fall) session_q <= 1'b0;

         // clear_session requires an empty FIFO, so no pop can coincide with it
         if (clear_session)                 rom_map <= '0;
         else if (pop && head_dat.addr[22]) rom_map[head_dat.addr[21:14]] <= 1'b1;

         if (clear_session)   rom_loaded <= 1'b0;
         else if (set_loaded) rom_loaded <= 1'b1;

         if (clear_session)                    drop_count <= drop ? 16'd1 : 16'd0;
         else if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
   end

endmodule
